seq_alu: RTL and testbench

Parametrised, clocked successor of the 3-bit switch-driven ALU. It holds two W-bit operand registers and a latched op-code. Operations are started with a `run` strobe and results are written into a registered accumulator `C`, with busy/done status. Single-cycle ops complete in one EXEC cycle; multiplication is a W-cycle shift-add sequence. It sits between the operand switches/loader and the LED/accumulator readout.

---
 rtl/seq_alu.sv | 152 +++++++++++++++
 tb/tb_seq_alu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: clocked W-bit ALU with operand registers, run/busy/done/err handshake.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier for op 0010; otherwise that op is illegal.
module seq_alu #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         load1,
    input  logic         load2,
    input  logic [3:0]   op_code,
    input  logic         run,
    output logic [W-1:0] C,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t       state, state_nx;
    logic [W-1:0] reg_a, reg_b, op_a, op_b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         res_ovf, res_ok;
    logic [W:0]   sum;

`ifdef SEQ_ALU_MUL_EN
    localparam int         CW     = $clog2(W + 1);
    localparam logic [3:0] OP_MUL = 4'b0010;

    logic [2*W-1:0] prod, prod_nx, mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           mul_last;

    assign prod_nx  = prod + (mplier[0] ? mcand : '0);
    assign mul_last = (cnt == CW'(1));
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (run) begin
`ifdef SEQ_ALU_MUL_EN
                state_nx = (op_code == OP_MUL) ? MUL : EXEC;
`else
                state_nx = EXEC;
`endif
            end
            EXEC: state_nx = IDLE;
            MUL: begin
`ifdef SEQ_ALU_MUL_EN
                if (mul_last) state_nx = IDLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle ops; op 0010 only reaches here when the multiplier is absent.
    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        res     = '0;
        res_ovf = 1'b0;
        res_ok  = 1'b1;
        case (op)
            4'b0000: {res_ovf, res} = sum;
            4'b0001: res = op_a ^ op_b;
            4'b0011: res = op_a << 2;
            4'b0100: res = op_a >> 2;
            4'b0101: res = op_a & op_b;
            4'b0110: res = op_a | op_b;
            4'b0111: res = ~(op_a & op_b);
            4'b1000: res = ~(op_a | op_b);
            4'b1001: res = op_a << 1;
            4'b1010: res = op_a >> 1;
            default: res_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op     <= '0;
            C      <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (load1) reg_a <= A;
            if (load2) reg_b <= B;
            case (state)
                IDLE: if (run) begin
                    op_a   <= reg_a;
                    op_b   <= reg_b;
                    op     <= op_code;
`ifdef SEQ_ALU_MUL_EN
                    prod   <= '0;
                    mcand  <= {{W{1'b0}}, reg_a};
                    mplier <= reg_b;
                    cnt    <= CW'(W);
`endif
                end
                EXEC: begin
                    if (res_ok) begin
                        C    <= res;
                        ovf  <= res_ovf;
                        done <= 1'b1;
                    end else begin
                        err  <= 1'b1;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    prod   <= prod_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (mul_last) begin
                        C    <= prod_nx[W-1:0];
                        ovf  <= |prod_nx[2*W-1:W];
                        done <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed plus randomized checks of seq_alu against a transaction-level model.
// Follows SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;
    localparam int W    = 3;
    localparam int MASK = (1 << W) - 1;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0, B = '0;
    logic         load1 = 1'b0, load2 = 1'b0, run = 1'b0;
    logic [3:0]   op_code = '0;
    logic [W-1:0] C;
    logic         busy, done, err, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.W(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .load1(load1), .load2(load2),
        .op_code(op_code), .run(run), .C(C), .busy(busy), .done(done),
        .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Model: on acceptance the whole result is computed arithmetically and held
    // until its latency (1 cycle, or W cycles for multiply) has elapsed.
    typedef struct packed {
        logic [W-1:0] res;
        logic         o;
        logic         il;
    } pred_t;

    function automatic pred_t predict(input logic [3:0] opc, input int a, input int b);
        pred_t p;
        int    full;
        p    = '0;
        full = 0;
        case (opc)
            4'd0:  begin full = a + b; p.o = (full > MASK); end
            4'd1:  full = a ^ b;
            4'd2:  if (MUL_EN) begin full = a * b; p.o = (full > MASK); end
                   else p.il = 1'b1;
            4'd3:  full = a << 2;
            4'd4:  full = a >> 2;
            4'd5:  full = a & b;
            4'd6:  full = a | b;
            4'd7:  full = ~(a & b);
            4'd8:  full = ~(a | b);
            4'd9:  full = a << 1;
            4'd10: full = a >> 1;
            default: p.il = 1'b1;
        endcase
        p.res = W'(full & MASK);
        return p;
    endfunction

    logic [W-1:0] e_c, m_a, m_b;
    logic         e_ovf, e_busy, e_done, e_err;
    int           left;
    pred_t        pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_c <= '0; e_ovf <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_err <= 1'b0;
            m_a <= '0; m_b <= '0; left <= 0; pend <= '0;
        end else begin
            e_done <= 1'b0;
            e_err  <= 1'b0;
            if (load1) m_a <= A;
            if (load2) m_b <= B;
            if (left != 0) begin
                left <= left - 1;
                if (left == 1) begin
                    e_busy <= 1'b0;
                    if (pend.il) e_err <= 1'b1;
                    else begin
                        e_c    <= pend.res;
                        e_ovf  <= pend.o;
                        e_done <= 1'b1;
                    end
                end
            end else if (run) begin
                pend   <= predict(op_code, int'(m_a), int'(m_b));
                left   <= (op_code == 4'd2 && MUL_EN) ? W : 1;
                e_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
        chk(nm, dut_v, exp);
        chk({nm, "_model"}, mdl_v, exp);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_C", C, e_c);
            chk("cyc_ovf", ovf, e_ovf);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_done", done, e_done);
            chk("cyc_err", err, e_err);
        end
    end

    task automatic load(input int a, input int b);
        A = W'(a); B = W'(b); load1 = 1'b1; load2 = 1'b1;
        @(negedge clk);
        load1 = 1'b0; load2 = 1'b0;
    endtask

    task automatic wait_idle(input bit extra, output int bc);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            @(negedge clk);
            if (extra && bc == 1) run = 1'b0;
        end
        run = 1'b0;
        chk("idle_timeout", busy, 0);
    endtask

    // Issues at the current negedge; returns at the negedge of the completion cycle.
    task automatic run_op(input logic [3:0] opc, input bit extra, output int bc);
        op_code = opc; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        if (extra) begin run = 1'b1; op_code = 4'd0; end
        wait_idle(extra, bc);
    endtask

    logic [3:0] ops [9] = '{4'd1, 4'd5, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd6};
    int         exps[9] = '{7, 0, 4, 1, 7, 0, 2, 2, 7};

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        lit("rst_C", C, e_c, 0);
        lit("rst_busy", busy, e_busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        load(5, 2);
        run_op(4'd0, 1'b0, bc);
        lit("add_C", C, e_c, 7);
        chk("add_ovf", ovf, 0);
        chk("add_done", done, 1);
        chk("add_lat", bc, 1);
        load(2, 5);
        run_op(4'd0, 1'b0, bc);
        lit("add2_C", C, e_c, 7);
        load(7, 1);
        run_op(4'd0, 1'b0, bc);
        lit("addc_C", C, e_c, 0);
        lit("addc_ovf", ovf, e_ovf, 1);

        load(5, 2);
        foreach (ops[i]) begin
            run_op(ops[i], 1'b0, bc);
            lit("op_C", C, e_c, exps[i]);
            chk("op_done", done, 1);
            chk("op_lat", bc, 1);
        end

        run_op(4'd2, 1'b1, bc);
        lit("mul_C", C, e_c, MUL_EN ? 2 : 7);
        lit("mul_ovf", ovf, e_ovf, MUL_EN ? 1 : 0);
        chk("mul_done", done, MUL_EN ? 1 : 0);
        chk("mul_err", err, MUL_EN ? 0 : 1);
        chk("mul_busy_cycles", bc, MUL_EN ? W : 1);
        @(negedge clk);
        chk("mul_no_requeue", busy, 0);

        run_op(4'd6, 1'b0, bc);
        run_op(4'd15, 1'b0, bc);
        lit("ill_C", C, e_c, 7);
        chk("ill_err", err, 1);
        chk("ill_done", done, 0);

        op_code = 4'd2; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        lit("abort_C", C, e_c, 0);
        lit("abort_busy", busy, e_busy, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        load(5, 2);
        A = W'(3); load1 = 1'b1; op_code = 4'd0; run = 1'b1;
        @(negedge clk);
        load1 = 1'b0; run = 1'b0;
        wait_idle(1'b0, bc);
        lit("ldrun_C", C, e_c, 7);
        run_op(4'd0, 1'b0, bc);
        lit("ldrun2_C", C, e_c, 5);

        repeat (600) begin
            rst     = ($urandom_range(0, 99) == 0);
            A       = W'($urandom);
            B       = W'($urandom);
            load1   = ($urandom_range(0, 3) == 0);
            load2   = ($urandom_range(0, 3) == 0);
            run     = ($urandom_range(0, 2) == 0);
            op_code = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst = 1'b0; load1 = 1'b0; load2 = 1'b0; run = 1'b0;
        repeat (2 * W + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
